// File: rtl/tomasulo_cdb_arb_if.sv
// tomasulo_cdb_arb_if: functional-unit result ports and the registered CDB broadcast.
interface tomasulo_cdb_arb_if #(
    parameter int TAG_W = 5,
    parameter int W     = 32
);
    logic             arith_vld, logic_vld, mpy_vld;
    logic [TAG_W-1:0] arith_tag, logic_tag, mpy_tag;
    logic [W-1:0]     arith_wdata, logic_wdata, mpy_wdata;
    logic             arith_rdy, logic_rdy, mpy_rdy;
    logic             cdb_vld;
    logic [TAG_W-1:0] cdb_tag;
    logic [W-1:0]     cdb_wdata;
    logic [1:0]       cdb_src;

    modport master (
        output arith_vld, arith_tag, arith_wdata,
        output logic_vld, logic_tag, logic_wdata,
        output mpy_vld, mpy_tag, mpy_wdata,
        input  arith_rdy, logic_rdy, mpy_rdy,
        input  cdb_vld, cdb_tag, cdb_wdata, cdb_src
    );

    modport slave (
        input  arith_vld, arith_tag, arith_wdata,
        input  logic_vld, logic_tag, logic_wdata,
        input  mpy_vld, mpy_tag, mpy_wdata,
        output arith_rdy, logic_rdy, mpy_rdy,
        output cdb_vld, cdb_tag, cdb_wdata, cdb_src
    );
endinterface

// File: rtl/tomasulo_cdb_arb.sv
// tomasulo_cdb_arb: per-unit result FIFOs with round-robin grant onto a registered CDB.
module tomasulo_cdb_arb #(
    parameter int Q_N   = 2,
    parameter int TAG_W = 5,
    parameter int W     = 32
) (
    input logic               clk,
    input logic               rst_n,
    tomasulo_cdb_arb_if.slave bus
);
    localparam int CW = $clog2(Q_N + 1);
    localparam int PW = Q_N > 1 ? $clog2(Q_N) : 1;
    localparam int EW = TAG_W + W;

    logic [EW-1:0]    mem_q [3][Q_N];
    logic [EW-1:0]    mem_d [3][Q_N];
    logic [CW-1:0]    cnt_q [3];
    logic [CW-1:0]    cnt_d [3];
    logic [PW-1:0]    head_q [3];
    logic [PW-1:0]    head_d [3];
    logic [PW-1:0]    tail_q [3];
    logic [PW-1:0]    tail_d [3];
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic             cdb_vld_q, cdb_vld_d;
    logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
    logic [W-1:0]     cdb_wdata_q, cdb_wdata_d;
    logic [1:0]       cdb_src_q, cdb_src_d;
    logic [EW-1:0]    in_ent [3];
    logic [2:0]       vld, rdy, ne, push, pop;
    logic [1:0]       o1, o2, win;
    logic             grant;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(Q_N - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        vld       = {bus.mpy_vld, bus.logic_vld, bus.arith_vld};
        in_ent[0] = {bus.arith_tag, bus.arith_wdata};
        in_ent[1] = {bus.logic_tag, bus.logic_wdata};
        in_ent[2] = {bus.mpy_tag, bus.mpy_wdata};
        for (int i = 0; i < 3; i++) begin
            rdy[i] = cnt_q[i] != CW'(Q_N);
            ne[i]  = cnt_q[i] != '0;
        end
        // rotate-priority search: rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3)
        o1    = rr_ptr_q == 2'd2 ? 2'd0 : rr_ptr_q + 2'd1;
        o2    = rr_ptr_q == 2'd0 ? 2'd2 : rr_ptr_q - 2'd1;
        grant = |ne;
        win   = ne[rr_ptr_q] ? rr_ptr_q : ne[o1] ? o1 : o2;
        mem_d = mem_q;
        for (int i = 0; i < 3; i++) begin
            push[i]   = vld[i] & rdy[i];
            pop[i]    = grant && win == 2'(i);
            cnt_d[i]  = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
            head_d[i] = pop[i] ? inc(head_q[i]) : head_q[i];
            tail_d[i] = push[i] ? inc(tail_q[i]) : tail_q[i];
            if (push[i])
                mem_d[i][tail_q[i]] = in_ent[i];
        end
        rr_ptr_d                 = grant ? (win == 2'd2 ? 2'd0 : win + 2'd1) : rr_ptr_q;
        cdb_vld_d                = grant;
        {cdb_tag_d, cdb_wdata_d} = grant ? mem_q[win][head_q[win]] : {cdb_tag_q, cdb_wdata_q};
        cdb_src_d                = grant ? win : cdb_src_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '{default: '0};
            head_q      <= '{default: '0};
            tail_q      <= '{default: '0};
            rr_ptr_q    <= '0;
            cdb_vld_q   <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_wdata_q <= '0;
            cdb_src_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_vld_q   <= cdb_vld_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_wdata_q <= cdb_wdata_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    // entry storage needs no reset: counts gate every read
    always_ff @(posedge clk)
        mem_q <= mem_d;

    assign bus.arith_rdy = rdy[0];
    assign bus.logic_rdy = rdy[1];
    assign bus.mpy_rdy   = rdy[2];
    assign bus.cdb_vld   = cdb_vld_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_wdata = cdb_wdata_q;
    assign bus.cdb_src   = cdb_src_q;

    for (genvar g = 0; g < 3; g++) begin : g_chk
        a_no_ovf: assert property (@(posedge clk) disable iff (!rst_n) !(push[g] && cnt_q[g] == CW'(Q_N)));
        a_no_udf: assert property (@(posedge clk) disable iff (!rst_n) !(pop[g] && cnt_q[g] == '0));
    end
endmodule

// File: tb/tb_tomasulo_cdb_arb.sv
// tb_tomasulo_cdb_arb: per-source scoreboard bench for the CDB arbiter
// covering reset, latency, round-robin order, fairness, back-pressure and mid-run reset.
module tb_tomasulo_cdb_arb;
    typedef logic [36:0] ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         n_chk = 0;
    int         n_err = 0;
    ent_t       sbq [3][$];
    logic [1:0] hist [$];
    logic [4:0] nxt_tag = 5'd10;
    ent_t       mon_e;
    int         mon_s;

    always #5 clk = ~clk;

    tomasulo_cdb_arb_if #(.TAG_W(5), .W(32)) bus ();
    tomasulo_cdb_arb #(.Q_N(2), .TAG_W(5), .W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, obs, exp);
        end
    endtask

    task automatic set_in(input int u, input logic v, input logic [4:0] t, input logic [31:0] d);
        case (u)
            0:       begin bus.arith_vld = v; bus.arith_tag = t; bus.arith_wdata = d; end
            1:       begin bus.logic_vld = v; bus.logic_tag = t; bus.logic_wdata = d; end
            default: begin bus.mpy_vld = v; bus.mpy_tag = t; bus.mpy_wdata = d; end
        endcase
    endtask

    function automatic logic rdy_of(input int u);
        return u == 0 ? bus.arith_rdy : u == 1 ? bus.logic_rdy : bus.mpy_rdy;
    endfunction

    // present a result that the bench expects to be accepted
    task automatic put(input int u, input logic [4:0] t, input logic [31:0] d);
        set_in(u, 1'b1, t, d);
        sbq[u].push_back({t, d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) set_in(u, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // fresh result on each selected unit; only a handshake that completes is expected
    task automatic drive(input logic [2:0] v);
        logic [31:0] d;
        for (int u = 0; u < 3; u++) begin
            if (v[u]) begin
                d = $urandom;
                if (rdy_of(u)) put(u, nxt_tag, d);
                else set_in(u, 1'b1, nxt_tag, d);
                nxt_tag++;
            end
        end
        tick();
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.cdb_vld === 1'b1) begin
            hist.push_back(bus.cdb_src);
            chk("cdb_src_legal", 64'(bus.cdb_src != 2'd3), 64'(1));
            if (bus.cdb_src != 2'd3) begin
                mon_s = int'(bus.cdb_src);
                chk("cdb_expected", 64'(sbq[mon_s].size() > 0), 64'(1));
                if (sbq[mon_s].size() > 0) begin
                    mon_e = sbq[mon_s].pop_front();
                    chk("cdb_tag", 64'(bus.cdb_tag), 64'(mon_e[36:32]));
                    chk("cdb_wdata", 64'(bus.cdb_wdata), 64'(mon_e[31:0]));
                end
            end
        end
    end

    initial begin
        int base;
        int lat;
        // reset held with every unit presenting a result
        for (int u = 0; u < 3; u++) set_in(u, 1'b1, 5'(u + 20), 32'hA5A5_0000 + u);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_rdy", 64'({bus.arith_rdy, bus.logic_rdy, bus.mpy_rdy}), 64'(3'b111));
            chk("rst_cdb", 64'({bus.cdb_vld, bus.cdb_src, bus.cdb_tag, bus.cdb_wdata}), 64'(0));
        end
        rst_n = 1'b1;
        for (int u = 0; u < 3; u++) set_in(u, 1'b0, 5'd0, 32'd0);
        tick();
        chk("rel_rdy", 64'({bus.arith_rdy, bus.logic_rdy, bus.mpy_rdy}), 64'(3'b111));
        chk("rel_cdb", 64'({bus.cdb_vld, bus.cdb_src, bus.cdb_tag, bus.cdb_wdata}), 64'(0));

        // single push: broadcast two cycles after the accepting edge, one cycle wide
        put(0, 5'd5, 32'hDEADBEEF);
        tick();
        chk("lat_t1_vld", 64'(bus.cdb_vld), 64'(0));
        tick();
        chk("lat_t2", 64'({bus.cdb_vld, bus.cdb_src, bus.cdb_tag, bus.cdb_wdata}),
            64'({1'b1, 2'd0, 5'd5, 32'hDEADBEEF}));
        tick();
        chk("lat_t3_vld", 64'(bus.cdb_vld), 64'(0));

        // a lone MPY grant brings rr_ptr back to 0
        put(2, 5'd9, $urandom);
        tick();
        idle(3);

        // three-way simultaneous push
        put(0, 5'd1, 32'h1111_0001);
        put(1, 5'd2, 32'h2222_0002);
        put(2, 5'd3, 32'h3333_0003);
        tick();
        chk("rr3_wait", 64'(bus.cdb_vld), 64'(0));
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rr3_bcast", 64'({bus.cdb_vld, bus.cdb_src, bus.cdb_tag}), 64'({1'b1, 2'(k), 5'(k + 1)}));
        end
        tick();
        chk("rr3_idle", 64'(bus.cdb_vld), 64'(0));

        // ARITH and MPY contend continuously
        base = hist.size();
        repeat (9) drive(3'b101);
        for (int k = 0; k < 6; k++)
            chk("rr_alt", 64'(hist[base + k]), 64'(k % 2 == 1 ? 2 : 0));

        // LOGIC joins and must be served within the fairness bound
        drive(3'b111);
        lat = 99;
        for (int k = 1; k <= 6; k++) begin
            if (lat == 99 && bus.cdb_vld === 1'b1 && bus.cdb_src == 2'd1) lat = k;
            drive(3'b101);
        end
        chk("logic_fair", 64'(lat >= 2 && lat <= 4), 64'(1));
        idle(10);
        put(2, 5'd9, $urandom);
        tick();
        idle(3);

        // LOGIC back-pressure with ARITH and MPY holding entries
        put(0, 5'd21, $urandom);
        put(1, 5'd22, $urandom);
        put(2, 5'd23, $urandom);
        tick();
        chk("bp_rdy_one", 64'(bus.logic_rdy), 64'(1));
        put(1, 5'd24, $urandom);
        tick();
        chk("bp_rdy_full", 64'(bus.logic_rdy), 64'(0));
        set_in(1, 1'b1, 5'd25, 32'hBAD0_0025);
        tick();
        chk("bp_rdy_back", 64'(bus.logic_rdy), 64'(1));
        chk("bp_pop", 64'({bus.cdb_vld, bus.cdb_src, bus.cdb_tag}), 64'({1'b1, 2'd1, 5'd22}));
        idle(6);

        // reset while queues hold entries and a broadcast is live
        repeat (3) drive(3'b111);
        chk("pre_rst_vld", 64'(bus.cdb_vld), 64'(1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int u = 0; u < 3; u++) sbq[u].delete();
        chk("mid_rst_rdy", 64'({bus.arith_rdy, bus.logic_rdy, bus.mpy_rdy}), 64'(3'b111));
        chk("mid_rst_cdb", 64'({bus.cdb_vld, bus.cdb_src, bus.cdb_tag, bus.cdb_wdata}), 64'(0));
        idle(6);
        put(1, 5'd30, 32'h0BAD_CAFE);
        tick();
        idle(4);

        for (int u = 0; u < 3; u++) chk("sb_drained", 64'(sbq[u].size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/tomasulo_cdb_arb.md
# tomasulo_cdb_arb

Common Data Bus (CDB) arbiter for the Tomasulo pipeline. It accepts completed results (tag + 32-bit word) from the three execution units (ARITH, LOGIC, MPY). Each result is buffered in a small per-unit queue, and one result per cycle is granted onto the single registered CDB with round-robin fairness. It sits between the functional-unit outputs and the reservation stations and register file, which all snoop `cdb_*`.

## Interface
- `Q_N`, default 2: per-unit queue depth in entries; must be at least 1.
- `TAG_W`, default 5: tag width, equal to `tag_t`.
- `W`, default 32: data width, equal to `word_t`.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `arith_vld`  in  1  ARITH result valid.
- `arith_tag`  in  TAG_W  ARITH result tag.
- `arith_wdata`  in  W  ARITH result data.
- `arith_rdy`  out  1  ARITH queue not full.
- `logic_vld` / `logic_tag` / `logic_wdata` / `logic_rdy`: same as the ARITH group, for LOGIC (index 1).
- `mpy_vld` / `mpy_tag` / `mpy_wdata` / `mpy_rdy`: same as the ARITH group, for MPY (index 2).
- `cdb_vld`  out  1  CDB broadcast valid, registered.
- `cdb_tag`  out  TAG_W  broadcast tag, registered.
- `cdb_wdata`  out  W  broadcast data, registered.
- `cdb_src`  out  2  source index of the broadcast (0 = ARITH, 1 = LOGIC, 2 = MPY), registered.

## Operation
- **Requester indices:** ARITH = 0, LOGIC = 1, MPY = 2.
- **Queues:** one Q_N-entry FIFO per unit, each with a count register.
  - `x_rdy = (count_x != Q_N)`. It depends only on state, never on `x_vld`.
- **Push:** `x_vld & x_rdy` writes {tag, wdata} at the tail.
  - `x_vld` while `!x_rdy` is ignored and the result is dropped.
  - Unit-side stall is the unit's responsibility.
- **No push-through-full:** a full queue does not accept a push even if it is popped in the same cycle. Pop and push in the same cycle on a non-full queue are both honoured, and the count is unchanged.
- **Arbitration:** combinational, over the non-empty queues.
  - Search order starts at `rr_ptr` and proceeds `rr_ptr`, `rr_ptr+1`, `rr_ptr+2` (mod 3).
  - The first non-empty queue wins and its head is popped.
- **Pointer update:** on a grant, `rr_ptr <= (winner + 1) mod 3`, wrapping 2 → 0. With no grant, `rr_ptr` holds.
- **CDB register:**
  - On a grant: `cdb_vld <= 1`, and `cdb_tag`, `cdb_wdata`, `cdb_src` take the winner's head.
  - With no grant: `cdb_vld <= 0`, and tag/data/src hold their previous values.
- **Arithmetic:** counts are `$clog2(Q_N+1)` bits wide; head/tail pointers wrap modulo Q_N. Overflow and underflow are impossible by construction; add assertions for both.
- **Fairness bound:** a non-empty queue is granted within 3 cycles.
- **Tags:** tag uniqueness is not checked (it is the dispatcher's responsibility).
- **Reset** (`rst_n = 0` sampled at an edge):
  - All counts and pointers become 0 and `rr_ptr` becomes 0.
  - `cdb_vld`, `cdb_tag`, `cdb_wdata` and `cdb_src` become 0.
  - Queued entries are discarded, with no broadcast of stale entries.
  - Pushes in the reset cycle are ignored.

## Timing
- **Reset values:**
  - `arith_rdy`, `logic_rdy`, `mpy_rdy` = 1, because queues are empty.
  - `cdb_vld` = 0, `cdb_tag` = 0, `cdb_wdata` = 0, `cdb_src` = 0.
- **Latency:** a push accepted at edge t is visible in the queue in cycle t+1. If it wins there, `cdb_vld` = 1 in cycle t+2. Minimum latency is 2 cycles.
- **Throughput:** at most 1 broadcast per cycle. Sustained full rate is achieved with any single active unit when Q_N ≥ 2.
- **Ready response:** `x_rdy` falls in the cycle after the push that fills the queue. It rises in the cycle after the pop that frees an entry.
- **Broadcast width:** `cdb_vld` is high for exactly one cycle per result. The CDB has no back-pressure.
- **Critical path:** the queue-head mux into the 3-way rotate-priority select into the CDB flops. There is no path from `x_vld` to `x_rdy`.

## Test plan
1. **Reset:** hold `rst_n = 0` for 3 cycles with all `vld = 1` → no queue accepts, all `rdy = 1`, `cdb_vld = 0`, tag/data/src = 0 throughout and one cycle after release.
2. **Single push latency:** ARITH pushes tag 5, data 0xDEADBEEF at edge t → cycle t+2 shows `cdb_vld = 1`, tag 5, data 0xDEADBEEF, src 0. `cdb_vld = 0` in cycle t+3.
3. **Simultaneous three-way:** all three units push once in the same cycle (tags 1, 2, 3) with `rr_ptr = 0` → broadcasts on 3 consecutive cycles in order tags 1, 2, 3, srcs 0, 1, 2. `rr_ptr` wraps to 0.
4. **Round-robin under contention:** ARITH and MPY keep queues non-empty continuously → grants alternate 0, 2, 0, 2. LOGIC is never granted and is never starved once it pushes: it is granted within 3 cycles.
5. **Back-pressure:** LOGIC pushes 3 results back-to-back with Q_N = 2 while MPY and ARITH also hold entries → `logic_rdy = 0` after the 2nd push, the 3rd is dropped if `vld` is held, and `rdy` returns 1 the cycle after the first LOGIC pop.
6. **Reset mid-operation:** with 2 entries queued per unit and `cdb_vld = 1`, assert `rst_n = 0` for one edge → next cycle `cdb_vld = 0`, all `rdy = 1`. No old tag ever appears on the CDB afterwards.
